// File: rtl/hysteresis_threshold_if.sv
`default_nettype none
// ============================================================================
//  Module      : hysteresis_threshold_if
//  Description : Whole-frame bus between the producer of a thinned gradient
//                magnitude frame and the hysteresis_threshold stage.
//                master : drives enable, thresholds and the input frame,
//                         and receives done, edge_pixel and pass_count.
//                slave  : the hysteresis stage, with the opposite directions.
//  Revision    : 1.0 - initial release
// ============================================================================
interface hysteresis_threshold_if #(
    parameter int WIDTH  = 5,
    parameter int HEIGHT = 5
);
    logic                enable;
    logic signed [15:0]  low_thresh;
    logic signed [15:0]  high_thresh;
    logic signed [15:0]  non_max_pixel [HEIGHT][WIDTH];
    logic                done;
    logic signed [15:0]  edge_pixel    [HEIGHT][WIDTH];
    logic [3:0]          pass_count;

    modport master (
        output enable, low_thresh, high_thresh, non_max_pixel,
        input  done, edge_pixel, pass_count
    );

    modport slave (
        input  enable, low_thresh, high_thresh, non_max_pixel,
        output done, edge_pixel, pass_count
    );
endinterface
`default_nettype wire

// File: rtl/hysteresis_threshold.sv
`default_nettype none
// ============================================================================
//  Module      : hysteresis_threshold
//  Description : Canny hysteresis stage. Classifies each pixel of the input
//                frame as strong / weak / none, repeatedly promotes weak
//                pixels touching a strong pixel (8-connectivity, in-place
//                raster scans), then clears any remaining weak pixels.
//  Ports       : clk  - rising-edge clock
//                rst  - synchronous active-high reset
//                bus  - hysteresis_threshold_if.slave (enable, thresholds,
//                       input frame, done pulse, edge map, pass count)
//  Revision    : 1.0 - initial release
// ============================================================================
module hysteresis_threshold #(
    parameter int WIDTH      = 5,
    parameter int HEIGHT     = 5,
    parameter int STRONG_VAL = 255,
    parameter int WEAK_VAL   = 25,
    parameter int MAX_PASSES = 8
) (
    input wire                     clk,
    input wire                     rst,
    hysteresis_threshold_if.slave  bus
);

    localparam int c_rw = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int c_cw = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;

    localparam logic [c_rw-1:0]    c_last_row   = c_rw'(HEIGHT - 1);
    localparam logic [c_cw-1:0]    c_last_col   = c_cw'(WIDTH - 1);
    localparam logic signed [15:0] c_strong     = 16'(STRONG_VAL);
    localparam logic signed [15:0] c_weak       = 16'(WEAK_VAL);
    // The pass counter is 4 bits wide, so the cap cannot exceed 15.
    localparam logic [3:0]         c_max_passes = (MAX_PASSES > 15) ? 4'd15 : 4'(MAX_PASSES);

    localparam logic [2:0] c_idle     = 3'd0;
    localparam logic [2:0] c_classify = 3'd1;
    localparam logic [2:0] c_scan     = 3'd2;
    localparam logic [2:0] c_check    = 3'd3;
    localparam logic [2:0] c_finalize = 3'd4;
    localparam logic [2:0] c_complete = 3'd5;

    logic [2:0]          r_state;
    logic [2:0]          w_next_state;
    logic [c_rw-1:0]     r_row;
    logic [c_cw-1:0]     r_col;
    logic                r_changed;
    logic [3:0]          r_pass_count;
    logic signed [15:0]  r_lo;
    logic signed [15:0]  r_hi;
    logic signed [15:0]  r_edge [HEIGHT][WIDTH];
    logic                w_done;

    logic                w_last_pixel;
    logic signed [15:0]  w_lo_eff;
    logic signed [15:0]  w_pixel;
    logic signed [15:0]  w_class;
    logic signed [15:0]  w_cur;
    logic                w_nbr;

    logic [WIDTH-1:0]    w_is_strong  [HEIGHT];
    logic [WIDTH-1:0]    w_nbr_strong [HEIGHT];

    assign w_last_pixel = (r_row == c_last_row) && (r_col == c_last_col);
    // With low above high, every pixel at or above high is strong and no weak band exists.
    assign w_lo_eff     = (bus.low_thresh < bus.high_thresh) ? bus.low_thresh : bus.high_thresh;
    assign w_pixel      = bus.non_max_pixel[r_row][r_col];
    assign w_cur        = r_edge[r_row][r_col];
    assign w_nbr        = w_nbr_strong[r_row][r_col];

    always_comb begin
        w_class = 16'sd0;
        if (w_pixel >= r_hi) begin
            w_class = c_strong;
        end else if (w_pixel >= r_lo) begin
            w_class = c_weak;
        end
    end

    // Per-pixel "strong pixel in the 3x3 window" flags. The window is clipped
    // at the frame border (clipped rows repeat the centre row, harmless in an
    // OR). The centre pixel is included: it only matters when it is weak,
    // in which case it contributes nothing.
    for (genvar gr = 0; gr < HEIGHT; gr++) begin : g_row
        for (genvar gc = 0; gc < WIDTH; gc++) begin : g_col
            localparam int c_r0 = (gr > 0)          ? gr - 1 : gr;
            localparam int c_r1 = (gr < HEIGHT - 1) ? gr + 1 : gr;
            localparam int c_c0 = (gc > 0)          ? gc - 1 : gc;
            localparam int c_c1 = (gc < WIDTH - 1)  ? gc + 1 : gc;

            assign w_is_strong[gr][gc]  = (r_edge[gr][gc] == c_strong);
            assign w_nbr_strong[gr][gc] = (|w_is_strong[c_r0][c_c1:c_c0]) |
                                          (|w_is_strong[gr][c_c1:c_c0])   |
                                          (|w_is_strong[c_r1][c_c1:c_c0]);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        if (!bus.enable) begin
            w_next_state = c_idle;
        end else begin
            case (r_state)
                c_idle:     w_next_state = c_classify;
                c_classify: if (w_last_pixel) w_next_state = c_scan;
                c_scan:     if (w_last_pixel) w_next_state = c_check;
                c_check:    w_next_state = (r_changed && (r_pass_count < c_max_passes)) ? c_scan : c_finalize;
                c_finalize: if (w_last_pixel) w_next_state = c_complete;
                c_complete: w_next_state = c_idle;
                default:    w_next_state = c_idle;
            endcase
        end
    end

    // Output logic
    always_comb begin
        w_done = (r_state == c_complete);
    end

    // Datapath: thresholds, raster position, pass bookkeeping and the edge map.
    // With enable low everything holds; IDLE re-initialises on the next run.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row        <= '0;
            r_col        <= '0;
            r_changed    <= 1'b0;
            r_pass_count <= 4'd0;
            r_lo         <= 16'sd0;
            r_hi         <= 16'sd0;
            for (int r = 0; r < HEIGHT; r++) begin
                for (int c = 0; c < WIDTH; c++) begin
                    r_edge[r][c] <= 16'sd0;
                end
            end
        end else if (bus.enable) begin
            case (r_state)
                c_idle: begin
                    r_lo         <= w_lo_eff;
                    r_hi         <= bus.high_thresh;
                    r_row        <= '0;
                    r_col        <= '0;
                    r_changed    <= 1'b0;
                    r_pass_count <= 4'd0;
                end
                c_classify: begin
                    r_edge[r_row][r_col] <= w_class;
                end
                c_scan: begin
                    if ((w_cur == c_weak) && w_nbr) begin
                        r_edge[r_row][r_col] <= c_strong;
                        r_changed            <= 1'b1;
                    end
                    if (w_last_pixel && (r_pass_count != 4'd15)) begin
                        r_pass_count <= r_pass_count + 4'd1;
                    end
                end
                c_check: begin
                    if (r_changed && (r_pass_count < c_max_passes)) begin
                        r_changed <= 1'b0;
                    end
                end
                c_finalize: begin
                    if (w_cur == c_weak) begin
                        r_edge[r_row][r_col] <= 16'sd0;
                    end
                end
                default: ;
            endcase

            // Raster advance; wraps to (0,0) so each visiting state starts at the origin.
            if ((r_state == c_classify) || (r_state == c_scan) || (r_state == c_finalize)) begin
                if (r_col == c_last_col) begin
                    r_col <= '0;
                    r_row <= (r_row == c_last_row) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    assign bus.done       = w_done;
    assign bus.edge_pixel = r_edge;
    assign bus.pass_count = r_pass_count;

endmodule
`default_nettype wire
